// File: rtl/fp_mult_pipe.sv
// -----------------------------------------------------------------------------
// fp_mult_pipe
//
// Pipelined fixed-point multiplier with a valid/ready handshake. Each operation
// is unsigned or two's-complement, selected per operation. The result is in the
// same Q format as the operands and saturates on overflow. The pipeline never
// inserts bubbles. Under backpressure it holds STAGES results.
//
// Parameters:
//   FP_WIDTH  operand/result width in bits
//   FP_FRAC   fractional bits (1..FP_WIDTH-1)
//   STAGES    registered stages (1..4), equal to the latency
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operand pair a/b/is_signed is valid
//   in_ready   operand pair is accepted this cycle
//   a, b       multiplicand, multiplier
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   out_valid  out/overflow hold a valid result
//   out_ready  consumer accepts the result this cycle
//   out        saturated product
//   overflow   result was saturated (qualified by out_valid)
//
// Optional feature:
//   FP_MULT_ROUND_EN  when defined, rounds half-up (toward +inf) before
//                     saturation. When undefined, the shift truncates
//                     toward -inf and no rounding adder is built.
// -----------------------------------------------------------------------------
module fp_mult_pipe #(
  parameter int FP_WIDTH = 16,
  parameter int FP_FRAC  = 8,
  parameter int STAGES   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_WIDTH-1:0] a,
  input  logic [FP_WIDTH-1:0] b,
  input  logic                is_signed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP_WIDTH-1:0] out,
  output logic                overflow
);

  localparam int W  = FP_WIDTH;
  // One extra bit beyond the 2W-bit product. This keeps the unsigned range,
  // the signed range and the rounding increment in one signed representation.
  localparam int PW = 2 * W + 1;

  localparam logic signed [PW-1:0] UMAX = {{(PW - W){1'b0}}, {W{1'b1}}};
  localparam logic signed [PW-1:0] SMAX = {{(PW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {{(PW - W + 1){1'b1}}, {(W - 1){1'b0}}};
`ifdef FP_MULT_ROUND_EN
  localparam logic signed [PW-1:0] RND  = {{(PW - 1){1'b0}}, 1'b1} << (FP_FRAC - 1);
`endif

  // The operands are extended (sign or zero) to PW bits before the multiply.
  // The true product always fits in PW bits, so the truncated result is exact.
  function automatic logic signed [PW-1:0] mul_full(input logic [W-1:0] x,
                                                    input logic [W-1:0] y,
                                                    input logic         sgn);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ye;
    xe = {{(PW - W){sgn & x[W-1]}}, x};
    ye = {{(PW - W){sgn & y[W-1]}}, y};
    return xe * ye;
  endfunction

  // Returns {overflow, result}. For unsigned operations the extended value is
  // never negative, so the arithmetic shift also acts as the logical shift.
  function automatic logic [W:0] saturate(input logic signed [PW-1:0] p,
                                          input logic                 sgn);
    logic signed [PW-1:0] r;
    logic signed [PW-1:0] sh;
`ifdef FP_MULT_ROUND_EN
    r = p + RND;
`else
    r = p;
`endif
    sh = r >>> FP_FRAC;
    if (sgn) begin
      if (sh > SMAX)      return {1'b1, 1'b0, {(W - 1){1'b1}}};
      else if (sh < SMIN) return {1'b1, 1'b1, {(W - 1){1'b0}}};
      else                return {1'b0, sh[W-1:0]};
    end else begin
      if (sh > UMAX)      return {1'b1, {W{1'b1}}};
      else                return {1'b0, sh[W-1:0]};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Stage occupancy and advance chain
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] adv;   // stage i loads new contents this cycle
  logic [STAGES-1:0] vin;   // validity of what would enter stage i

  // A stage can accept new contents when it is empty or its contents move on.
  // This ripples from out_ready back to in_ready in one cycle.
  always_comb begin : p_adv
    logic nxt;
    adv = '0;
    nxt = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = !valid_q[i] || nxt;
      nxt    = adv[i];
    end
  end

  always_comb begin
    vin    = '0;
    vin[0] = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      vin[i] = valid_q[i-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < STAGES; i++) begin
      if (adv[i]) valid_d[i] = vin[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand register, product register(s), result register
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] fin_prod;  // full product that enters the last stage
  logic                 fin_sgn;

  if (STAGES == 1) begin : g_s1
    // A single stage multiplies the live inputs directly into the result.
    assign fin_prod = mul_full(a, b, is_signed);
    assign fin_sgn  = is_signed;
  end else begin : g_sn
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         s_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= 1'b0;
      end else if (adv[0] && in_valid) begin
        a_q <= a;
        b_q <= b;
        s_q <= is_signed;
      end
    end

    if (STAGES == 2) begin : g_s2
      assign fin_prod = mul_full(a_q, b_q, s_q);
      assign fin_sgn  = s_q;
    end else begin : g_s3p
      // prod_q[j] belongs to stage j+1. Only the first one multiplies.
      // The remaining ones are plain delay registers.
      localparam int NP = STAGES - 2;
      logic signed [PW-1:0] prod_q [NP];
      logic                 psgn_q [NP];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j < NP; j++) begin
            prod_q[j] <= '0;
            psgn_q[j] <= 1'b0;
          end
        end else begin
          if (adv[1] && vin[1]) begin
            prod_q[0] <= mul_full(a_q, b_q, s_q);
            psgn_q[0] <= s_q;
          end
          for (int j = 1; j < NP; j++) begin
            if (adv[j+1] && vin[j+1]) begin
              prod_q[j] <= prod_q[j-1];
              psgn_q[j] <= psgn_q[j-1];
            end
          end
        end
      end

      assign fin_prod = prod_q[NP-1];
      assign fin_sgn  = psgn_q[NP-1];
    end
  end

  logic [W:0]   sat_d;
  logic [W-1:0] out_q;
  logic         ovf_q;

  assign sat_d = saturate(fin_prod, fin_sgn);

  // The result register loads only when a real result enters. Under
  // backpressure adv is low, so out and overflow stay put.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else if (adv[STAGES-1] && vin[STAGES-1]) begin
      out_q <= sat_d[W-1:0];
      ovf_q <= sat_d[W];
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign out       = out_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Pipelined, parametrised fixed-point multiplier. Successor to the combinational datapath multiplier.
- Adds a per-operation signed/unsigned mode, saturation with an overflow flag, and a valid/ready handshake with full backpressure.
- Sits in the skin-tone datapath between the operand formatter and the accumulator/classifier stages.
- Throughput is one product per clock when the downstream consumer is ready.

Parameters:
- FP_WIDTH, 16, total operand/result width in bits.
- FP_FRAC, 8, fractional bits; legal range 1..FP_WIDTH-1.
- STAGES, 3, pipeline depth in registered stages; legal range 1..4; equals latency.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair a/b/is_signed is valid
- in_ready  out  1  block accepts the operand pair this cycle
- a  in  FP_WIDTH  multiplicand
- b  in  FP_WIDTH  multiplier
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b
- out_valid  out  1  out/overflow hold a valid result
- out_ready  in  1  consumer accepts the result this cycle
- out  out  FP_WIDTH  product in the same Q format as the operands
- overflow  out  1  result was saturated; qualified by out_valid

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset: all stage valid bits cleared, so out_valid=0 and in_ready=1 in the cycle after reset. out and overflow reset to 0.
- Reset mid-operation discards every in-flight product; nothing is emitted afterwards.
- Handshake:
  - Transfer on the input when in_valid&&in_ready; on the output when out_valid&&out_ready.
  - Stage k advances when it is empty or stage k+1 advances. The last stage advances on out_ready.
  - in_ready = !valid[0] || advance[0], combinational from out_ready through the stage chain.
  - No bubbles are required; STAGES results can be held under backpressure.
- While out_valid=1 and out_ready=0, out and overflow are stable.
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+STAGES if no backpressure occurs.
- Ordering is strictly FIFO.
- Arithmetic:
  - Full 2*FP_WIDTH-bit product, sign- or zero-extended per is_signed.
  - Shift right by FP_FRAC: arithmetic when signed, logical when unsigned. This truncates toward -inf.
  - Saturate to FP_WIDTH bits:
    - Unsigned: result > 2^W-1 gives all ones.
    - Signed: result > 2^(W-1)-1 gives 0x7FF..F; result < -2^(W-1) gives 0x800..0.
  - overflow=1 exactly when saturation occurred.
- Stage partition:
  - Stage 1 registers operands.
  - The multiply occurs in stage 1 when STAGES=1, otherwise in stage 2.
  - Shift/round/saturate occurs in the final stage.
  - Intermediate stages are pure registers.
  - Functional results are identical for all STAGES values.
- is_signed travels with its operands; changing it between operations has no effect on in-flight products.

Optional Feature:
- Macro FP_MULT_ROUND_EN.
- Defined: round-half-up (toward +inf) before saturation. Add 2^(FP_FRAC-1) to the full product, then shift. Overflow caused by the rounding increment saturates and sets overflow.
- Undefined: pure truncation as above, with no rounding adder in the datapath.

Test Plan (FP_WIDTH=16, FP_FRAC=8, STAGES=3 unless noted):
- Basic unsigned: a=0x0180, b=0x0200, is_signed=0, out_ready=1 -> out=0x0300, overflow=0, out_valid exactly 3 cycles after acceptance.
- Signed and negative: a=0xFE80, b=0x0200, is_signed=1 -> out=0xFD00. Then a=0x7FFF, b=0x7FFF, signed -> out=0x7FFF, overflow=1. Then a=0x8000, b=0x7FFF, signed -> out=0x8000, overflow=1.
- Unsigned saturation: a=0x8000, b=0x0400, is_signed=0 -> out=0xFFFF, overflow=1.
- Rounding: a=0x0001, b=0x0080 -> out=0x0000 without FP_MULT_ROUND_EN, out=0x0001 with it. Also a=0x0001, b=0x007F -> 0x0000 in both builds.
- Backpressure:
  - Hold out_ready=0 and stream 5 back-to-back operations -> exactly 3 accepted, in_ready=0 afterwards, out stable.
  - Release out_ready -> all 5 results emitted in order with no loss or duplication, 1 per cycle.
  - Repeat with STAGES=1 and STAGES=4 -> 1 and 4 operations held respectively.
- Reset mid-stream: assert reset for 1 cycle with 2 operations in flight -> next cycle out_valid=0, in_ready=1, out=0, overflow=0. The in-flight products are never emitted.
